instr_fetch_unit: RTL
=====================

// Module: instr_fetch_unit
// PURPOSE
//  Multi-cycle fetch stage that sits upstream of the PC/IR/TR registers of the accumulator CPU.
//  Reads 8-bit instruction bytes from memory over a req/ack port.
//  Assembles the 8-bit IR and the 13-bit TR operand address, holds the 13-bit PC.
//  Hands one instruction at a time to the execute stage over a valid/ready handshake.
//  Accepts a redirect (jump/branch target) from execute.
// PARAMETERS
//  ADDR_W     13      PC/TR/memory address width
//  DATA_W     8       instruction byte width (IR width)
//  SHORT_OPC  3'b111  byte0[7:5] value marking a one-byte instruction; all others are two-byte
// PORTS
//  clk            in   1       clock; all state changes on posedge
//  rst            in   1       asynchronous, active-low reset (0 = reset)
//  mem_req        out  1       memory read request, registered
//  mem_addr       out  ADDR_W  read address, registered; stable while mem_req=1
//  mem_ack        in   1       read data valid this cycle; completes the request
//  mem_rdata      in   DATA_W  read data, sampled only when mem_ack=1
//  inst_valid     out  1       ir/tr/inst_pc hold a complete instruction
//  inst_ready     in   1       execute accepts the instruction (transfer = valid & ready)
//  ir             out  DATA_W  instruction byte0
//  tr             out  ADDR_W  operand address {byte0[4:0], byte1}; 0 for one-byte instructions
//  inst_pc        out  ADDR_W  address of byte0 of the presented instruction
//  pc             out  ADDR_W  address of the next byte to fetch
//  redirect_en    in   1       load pc from redirect_pc; flushes the fetch in progress
//  redirect_pc    in   ADDR_W  redirect target
// BEHAVIOUR
//  Reset (rst=0, async): state=FETCH1; pc=0, mem_addr=0, mem_req=0, inst_valid=0.
//   ir=0, tr=0, inst_pc=0.
//   First posedge after release: mem_req=1, mem_addr=pc.
//  Request rule: once mem_req=1, it stays high with mem_addr unchanged until the mem_ack cycle.
//   mem_req drops the cycle after ack, unless the next state issues a new request in that same edge.
//   Back-to-back requests are allowed.
//   mem_ack while mem_req=0 is ignored.
//  States:
//   FETCH1: req byte0 at pc. On ack: ir<=rdata, inst_pc<=pc, pc<=pc+1.
//    If rdata[7:5]==SHORT_OPC: tr<=0, go HOLD. Otherwise tr[12:8]<=rdata[4:0], go FETCH2
//    (new req at pc+1 issued on the same edge).
//   FETCH2: req byte1 at pc. On ack: tr[7:0]<=rdata, pc<=pc+1, go HOLD.
//   HOLD: inst_valid=1; ir/tr/inst_pc frozen. On inst_ready: inst_valid<=0, go FETCH1
//    (req issued on that edge, so mem_req=1 the next cycle).
//   DRAIN: request outstanding after a redirect. Keep req/addr until ack, discard data, go FETCH1.
//  Latency: ack in the last byte cycle -> inst_valid=1 the next cycle.
//   Minimum is 2 cycles per one-byte and 3 cycles per two-byte instruction with ack in the first cycle.
//  PC arithmetic: modulo 2^ADDR_W; pc=13'h1FFF increments to 0; a two-byte fetch may straddle the wrap.
//  Redirect (priority over everything except reset); pc<=redirect_pc in every state:
//   FETCH1/FETCH2 with ack same cycle: data discarded, go FETCH1 (next req at redirect_pc).
//   FETCH1/FETCH2 without ack: go DRAIN.
//   DRAIN: pc updated again (last target wins); stay in DRAIN.
//   HOLD: inst_valid<=0, go FETCH1. If inst_ready=1 in that same cycle, the transfer counts
//    (consumer keeps it); the redirect still applies.
//  Reset mid-operation: immediate return to reset values. Any outstanding memory request is abandoned.
// TESTING
//  1 Reset, mem returns 8'hE5 at 0 with 0-cycle ack delay
//    -> ir=E5, tr=0, inst_pc=0, inst_valid 2 cycles after release; pc=1.
//  2 Bytes 8'h2A,8'h3C at addr 4,5, ack delay 2 cycles
//    -> ir=2A, tr=13'h0A3C, inst_pc=4, pc=6; mem_addr held stable during each wait.
//  3 inst_ready=0 for 5 cycles in HOLD
//    -> inst_valid, ir, tr frozen, mem_req=0; ready=1 -> next cycle mem_req=1, addr=pc.
//  4 Two-byte instruction at 13'h1FFF
//    -> byte1 fetched from addr 0, pc=1 afterwards, inst_pc=1FFF.
//  5 redirect_en (target 13'h0100) in FETCH2 with ack 3 cycles late
//    -> DRAIN, stale byte discarded, next req at 0100, no inst_valid for the flushed instruction.
//  6 redirect_en & inst_ready in HOLD (target 13'h0040)
//    -> transfer counted, inst_valid=0 next cycle, next req at 0040.

Source files
------------

// File: rtl/instr_fetch_unit_if.sv
// Fetch-unit bundle: memory read port, instruction hand-off to execute, and redirect input.
// master = fetch unit side, slave = memory/execute side.
interface instr_fetch_unit_if #(
  parameter int unsigned ADDR_W = 13,
  parameter int unsigned DATA_W = 8
);
  logic              mem_req;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_ack;
  logic [DATA_W-1:0] mem_rdata;
  logic              inst_valid;
  logic              inst_ready;
  logic [DATA_W-1:0] ir;
  logic [ADDR_W-1:0] tr;
  logic [ADDR_W-1:0] inst_pc;
  logic [ADDR_W-1:0] pc;
  logic              redirect_en;
  logic [ADDR_W-1:0] redirect_pc;

  modport master (
    output mem_req, mem_addr, inst_valid, ir, tr, inst_pc, pc,
    input  mem_ack, mem_rdata, inst_ready, redirect_en, redirect_pc
  );

  modport slave (
    input  mem_req, mem_addr, inst_valid, ir, tr, inst_pc, pc,
    output mem_ack, mem_rdata, inst_ready, redirect_en, redirect_pc
  );
endinterface

// File: rtl/instr_fetch_unit.sv
// Multi-cycle instruction fetch: assembles IR/TR from one or two memory bytes,
// presents them on a valid/ready handshake and honours redirects from execute.
module instr_fetch_unit #(
  parameter int unsigned ADDR_W    = 13,
  parameter int unsigned DATA_W    = 8,
  parameter logic [2:0]  SHORT_OPC = 3'b111
) (
  input logic                clk,
  input logic                rst,
  instr_fetch_unit_if.master bus
);

  typedef enum logic [1:0] {FETCH1, FETCH2, HOLD, DRAIN} state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [ADDR_W-1:0] tr_q, tr_d;
  logic [ADDR_W-1:0] inst_pc_q, inst_pc_d;
  logic [DATA_W-1:0] ir_q, ir_d;
  logic              mem_req_q, mem_req_d;
  logic              inst_valid_q, inst_valid_d;

  logic              ack;
  logic              is_short;
  logic [ADDR_W-1:0] pc_inc;

  // An ack only completes a request we actually have outstanding.
  assign ack      = bus.mem_ack & mem_req_q;
  assign is_short = (bus.mem_rdata[DATA_W-1 -: 3] == SHORT_OPC);
  assign pc_inc   = pc_q + ADDR_W'(1);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= FETCH1;
      pc_q         <= '0;
      mem_addr_q   <= '0;
      mem_req_q    <= 1'b0;
      inst_valid_q <= 1'b0;
      ir_q         <= '0;
      tr_q         <= '0;
      inst_pc_q    <= '0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      mem_addr_q   <= mem_addr_d;
      mem_req_q    <= mem_req_d;
      inst_valid_q <= inst_valid_d;
      ir_q         <= ir_d;
      tr_q         <= tr_d;
      inst_pc_q    <= inst_pc_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      FETCH1: begin
        if (bus.redirect_en)  state_d = (!mem_req_q || ack) ? FETCH1 : DRAIN;
        else if (ack)         state_d = is_short ? HOLD : FETCH2;
      end
      FETCH2: begin
        if (bus.redirect_en)  state_d = ack ? FETCH1 : DRAIN;
        else if (ack)         state_d = HOLD;
      end
      HOLD: begin
        if (bus.redirect_en || bus.inst_ready) state_d = FETCH1;
      end
      DRAIN: begin
        if (ack)              state_d = FETCH1;
      end
      default:                state_d = FETCH1;
    endcase
  end

  // Every transition back into a fetch state issues its request on the same edge,
  // so mem_req only drops when the next state is HOLD.
  always_comb begin
    pc_d         = pc_q;
    mem_addr_d   = mem_addr_q;
    mem_req_d    = mem_req_q;
    inst_valid_d = inst_valid_q;
    ir_d         = ir_q;
    tr_d         = tr_q;
    inst_pc_d    = inst_pc_q;
    unique case (state_q)
      FETCH1: begin
        if (bus.redirect_en) begin
          pc_d = bus.redirect_pc;
          if (!mem_req_q || ack) begin
            mem_req_d  = 1'b1;
            mem_addr_d = bus.redirect_pc;
          end
        end else if (!mem_req_q) begin
          mem_req_d  = 1'b1;
          mem_addr_d = pc_q;
        end else if (ack) begin
          ir_d      = bus.mem_rdata;
          inst_pc_d = pc_q;
          pc_d      = pc_inc;
          if (is_short) begin
            tr_d         = '0;
            mem_req_d    = 1'b0;
            inst_valid_d = 1'b1;
          end else begin
            tr_d[ADDR_W-1:DATA_W] = bus.mem_rdata[ADDR_W-DATA_W-1:0];
            mem_addr_d            = pc_inc;
          end
        end
      end
      FETCH2: begin
        if (bus.redirect_en) begin
          pc_d = bus.redirect_pc;
          if (ack) mem_addr_d = bus.redirect_pc;
        end else if (ack) begin
          tr_d[DATA_W-1:0] = bus.mem_rdata;
          pc_d             = pc_inc;
          mem_req_d        = 1'b0;
          inst_valid_d     = 1'b1;
        end
      end
      HOLD: begin
        if (bus.redirect_en || bus.inst_ready) begin
          inst_valid_d = 1'b0;
          mem_req_d    = 1'b1;
          mem_addr_d   = bus.redirect_en ? bus.redirect_pc : pc_q;
          if (bus.redirect_en) pc_d = bus.redirect_pc;
        end
      end
      DRAIN: begin
        if (bus.redirect_en) pc_d = bus.redirect_pc;
        if (ack) mem_addr_d = bus.redirect_en ? bus.redirect_pc : pc_q;
      end
      default: ;
    endcase
  end

  assign bus.mem_req    = mem_req_q;
  assign bus.mem_addr   = mem_addr_q;
  assign bus.inst_valid = inst_valid_q;
  assign bus.ir         = ir_q;
  assign bus.tr         = tr_q;
  assign bus.inst_pc    = inst_pc_q;
  assign bus.pc         = pc_q;

endmodule
